// File: rtl/lzd_decomposable_pipe_pkg.sv
// Shared definitions for the decomposable leading-count pipeline: lane split encoding and
// count-width helper.
package lzd_decomposable_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_EIGHTH  = 2'd3
    } mode_e;

    // One extra bit so an all-matching lane can report its full width.
    function automatic int unsigned cnt_width(input int unsigned bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/lzc_leaf.sv
// Leading-ones count and all-ones flag of one minimum-width segment.
module lzc_leaf
    import lzd_decomposable_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] seg,
    output logic [CW-1:0]    cnt,
    output logic             all
);

    logic found;

    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (!found) begin
                if (seg[i]) begin
                    cnt = cnt + CW'(1);
                end else begin
                    found = 1'b1;
                end
            end
        end
        all = &seg;
    end

endmodule

// File: rtl/lzd_decomposable_pipe.sv
// Two-stage leading-one/zero counter whose word can be split into 1, 2, 4 or 8 equal lanes.
// S1 holds per-segment leaf results; S2 holds the lane results merged for the requested split.
module lzd_decomposable_pipe
    import lzd_decomposable_pipe_pkg::*;
#(
    parameter int unsigned MAX_BITS  = 32,
    parameter int unsigned N_LEVELS  = 3,
    localparam int unsigned N_LANES  = 1 << (N_LEVELS - 1),
    localparam int unsigned LANE_MIN = MAX_BITS / N_LANES,
    localparam int unsigned CNT_W    = cnt_width(MAX_BITS),
    localparam int unsigned MODE_W   = (N_LEVELS > 2) ? $clog2(N_LEVELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MAX_BITS-1:0]        in_data,
    input  logic [MODE_W-1:0]          in_mode,
    input  logic                       in_pol,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_LANES*CNT_W-1:0]   out_cnt,
    output logic [N_LANES-1:0]         out_all,
    output logic [MODE_W-1:0]          out_mode
);

    localparam int unsigned LCW = cnt_width(LANE_MIN);

    // Counting zeros is counting ones of the inverted word.
    logic [MAX_BITS-1:0] scan;
    logic [MODE_W-1:0]   mode_c;

    assign scan   = in_data ^ {MAX_BITS{in_pol}};
    assign mode_c = (32'(in_mode) >= N_LEVELS) ? MODE_W'(N_LEVELS - 1) : in_mode;

    logic [LCW-1:0]     leaf_cnt [N_LANES];
    logic [N_LANES-1:0] leaf_all;

    for (genvar j = 0; j < N_LANES; j++) begin : g_leaf
        lzc_leaf #(
            .WIDTH (LANE_MIN)
        ) u_leaf (
            .seg (scan[j*LANE_MIN +: LANE_MIN]),
            .cnt (leaf_cnt[j]),
            .all (leaf_all[j])
        );
    end

    logic               s1_valid;
    logic [LCW-1:0]     s1_cnt [N_LANES];
    logic [N_LANES-1:0] s1_all;
    logic [MODE_W-1:0]  s1_mode;
    logic               s1_advance;
    logic               s2_load;

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = rst_n && (!s1_valid || s1_advance);

    // Level l node k spans LANE_MIN << l bits; level N_LEVELS-1-m gives the mode-m lanes.
    logic [CNT_W-1:0] tcnt [N_LEVELS][N_LANES];
    logic             tall [N_LEVELS][N_LANES];

    for (genvar l = 0; l < N_LEVELS; l++) begin : g_lvl
        for (genvar k = 0; k < N_LANES; k++) begin : g_node
            if (l == 0) begin : g_base
                assign tcnt[0][k] = CNT_W'(s1_cnt[k]);
                assign tall[0][k] = s1_all[k];
            end else if (k < (N_LANES >> l)) begin : g_merge
                assign tall[l][k] = tall[l-1][2*k] & tall[l-1][2*k+1];
                assign tcnt[l][k] = tall[l-1][2*k+1]
                                  ? CNT_W'(LANE_MIN << (l - 1)) + tcnt[l-1][2*k]
                                  : tcnt[l-1][2*k+1];
            end else begin : g_pad
                assign tall[l][k] = 1'b0;
                assign tcnt[l][k] = '0;
            end
        end
    end

    logic [N_LANES*CNT_W-1:0] cnt_d;
    logic [N_LANES-1:0]       all_d;
    logic [MODE_W-1:0]        lvl;

    always_comb begin
        cnt_d = '0;
        all_d = '0;
        lvl   = MODE_W'(N_LEVELS - 1) - s1_mode;
        for (int k = 0; k < int'(N_LANES); k++) begin
            if (32'(k) < (32'(1) << s1_mode)) begin
                cnt_d[k*CNT_W +: CNT_W] = tcnt[lvl][k];
                all_d[k]                = tall[lvl][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_all    <= '0;
            s1_mode   <= '0;
            for (int j = 0; j < int'(N_LANES); j++) begin
                s1_cnt[j] <= '0;
            end
            out_valid <= 1'b0;
            out_cnt   <= '0;
            out_all   <= '0;
            out_mode  <= '0;
        end else begin
            if (!s1_valid || s1_advance) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_cnt  <= leaf_cnt;
                    s1_all  <= leaf_all;
                    s1_mode <= mode_c;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_cnt  <= cnt_d;
                    out_all  <= all_d;
                    out_mode <= s1_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_lzd_decomposable_pipe.sv
// Self-checking bench: directed vectors, backpressure, mid-stream reset and a random stream
// scored against a behavioural lane-count model.
module tb_lzd_decomposable_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        in_pol;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_cnt;
    logic [3:0]  out_all;
    logic [1:0]  out_mode;

    lzd_decomposable_pipe #(
        .MAX_BITS (32),
        .N_LEVELS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_pol    (in_pol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt),
        .out_all   (out_all),
        .out_mode  (out_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [23:0] cnt;
        logic [3:0]  all;
        logic [1:0]  mode;
    } exp_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  q[$];
    bit    acc;
    bit    held_v;
    logic [23:0] held_cnt;
    logic [3:0]  held_all;
    logic [1:0]  held_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Lane k of a 2^m split covers 32/2^m bits; count leading ones of the (polarity-adjusted) word.
    function automatic exp_t model(input logic [31:0] d, input logic [1:0] mode, input logic pol);
        exp_t        r;
        int          m;
        int          w;
        int          n;
        logic [31:0] x;
        r = '0;
        m = (int'(mode) > 2) ? 2 : int'(mode);
        x = pol ? ~d : d;
        w = 32 >> m;
        r.mode = 2'(m);
        for (int k = 0; k < (1 << m); k++) begin
            n = 0;
            for (int i = w - 1; i >= 0; i--) begin
                if (x[k*w+i]) n++;
                else break;
            end
            r.cnt[k*6 +: 6] = 6'(n);
            r.all[k]        = (n == w);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return r;
            1: return r >> $urandom_range(0, 32);
            2: return ~(r >> $urandom_range(0, 32));
            default: begin
                for (int j = 0; j < 4; j++) begin
                    case ($urandom_range(0, 2))
                        0: r[j*8 +: 8] = 8'h00;
                        1: r[j*8 +: 8] = 8'hFF;
                        default: r[j*8 +: 8] = 8'($urandom);
                    endcase
                end
                return r;
            end
        endcase
    endfunction

    // Called at a negedge after inputs are set; returns at the next negedge.
    task automatic cycle(output bit accepted);
        exp_t e;
        #1;
        accepted = in_valid && in_ready && rst_n;
        if (accepted) q.push_back(model(in_data, in_mode, in_pol));
        if (out_valid && out_ready && rst_n) begin
            chk("sb_nonempty", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_cnt", out_cnt, e.cnt);
                chk("sb_all", out_all, e.all);
                chk("sb_mode", out_mode, e.mode);
            end
        end
        held_v    = out_valid && !out_ready && rst_n;
        held_cnt  = out_cnt;
        held_all  = out_all;
        held_mode = out_mode;
        @(posedge clk);
        @(negedge clk);
        if (held_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_cnt", out_cnt, held_cnt);
            chk("hold_all", out_all, held_all);
            chk("hold_mode", out_mode, held_mode);
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] d, input logic [1:0] mode,
                            input logic pol, input logic [23:0] ecnt, input logic [3:0] eall,
                            input logic [1:0] emode);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = mode;
        in_pol    = pol;
        out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        cycle(acc);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        cycle(acc);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_cnt"}, out_cnt, ecnt);
        chk({tag, "_all"}, out_all, eall);
        chk({tag, "_mode"}, out_mode, emode);
        cycle(acc);
    endtask

    function automatic logic [23:0] pack4(input int c3, input int c2, input int c1, input int c0);
        return {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
    endfunction

    logic [31:0] bp_data [5];
    int          idx;
    int          stall_left;
    bit          seen;
    int          sent;
    bit          have;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_pol    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        repeat (3) cycle(acc);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_out_cnt", out_cnt, 0);
        chk("rel_out_all", out_all, 0);
        chk("rel_out_mode", out_mode, 0);

        directed("full_half", 32'hFFFF_0000, 2'd0, 1'b0, pack4(0, 0, 0, 16), 4'b0000, 2'd0);
        directed("full_all", 32'hFFFF_FFFF, 2'd0, 1'b0, pack4(0, 0, 0, 32), 4'b0001, 2'd0);
        directed("halves", 32'hC000_FFFF, 2'd1, 1'b0, pack4(0, 0, 2, 16), 4'b0001, 2'd1);
        directed("quart_z", 32'h0001_00FF, 2'd2, 1'b1, pack4(8, 7, 8, 0), 4'b1010, 2'd2);
        directed("mode_clamp", 32'hFF00_FF0F, 2'd3, 1'b0, pack4(8, 0, 8, 0), 4'b1010, 2'd2);
        directed("full_zeros", 32'h0000_0000, 2'd0, 1'b1, pack4(0, 0, 0, 32), 4'b0001, 2'd0);

        // Backpressure: five back-to-back, out_ready low for 4 cycles from the first out_valid.
        for (int i = 0; i < 5; i++) bp_data[i] = rand_word();
        idx        = 0;
        stall_left = 0;
        seen       = 1'b0;
        in_mode    = 2'd2;
        in_pol     = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!seen && out_valid) begin
                seen       = 1'b1;
                stall_left = 4;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                #1 chk("bp_in_ready_low", in_ready, 0);
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (idx < 5);
            if (idx < 5) in_data = bp_data[idx];
            cycle(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", idx, 5);
        chk("bp_drained", q.size(), 0);

        // Reset with two transactions in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hF0F0_F0F0;
        cycle(acc);
        in_data   = 32'hFFFF_FF00;
        cycle(acc);
        chk("rstm_busy", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        cycle(acc);
        chk("rstm_out_valid", out_valid, 0);
        chk("rstm_out_cnt", out_cnt, 0);
        chk("rstm_in_ready", in_ready, 0);
        rst_n = 1'b1;
        q.delete();
        #1 chk("rstm_rel_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(acc);
            chk("rstm_no_stale", out_valid, 0);
        end

        // Random stream with random valid/ready gaps.
        sent = 0;
        have = 1'b0;
        for (int c = 0; c < 2500 && sent < 300; c++) begin
            if (!have) begin
                in_data = rand_word();
                in_mode = 2'($urandom_range(0, 3));
                in_pol  = 1'($urandom_range(0, 1));
                have    = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
            if (acc) begin
                sent++;
                have = 1'b0;
            end
        end
        chk("rand_sent", sent, 300);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle(acc);
        chk("rand_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
